// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder for the core's data-memory request port.
//             Accepts one load/store per valid/ready handshake. Waits a fixed
//             number of cycles, then commits the access to a word-organised
//             RAM and returns a one-cycle response. Handles byte-lane store
//             merging and load extraction with sign or zero extension.
//  Ports    : clk, rst            clock / synchronous active-high reset
//             req_valid/req_ready request handshake
//             req_we, req_size,   store flag, size (00 B, 01 H, 10 W, 11 rsvd),
//             req_unsigned        load zero-extend flag
//             req_addr/req_wdata  byte address, store data
//             resp_valid          one-cycle response pulse
//             resp_rdata/resp_err load data (0 for stores/errors), fault flag
//             busy                high in WAIT or RESP (stall source)
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned c_WORDS    = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  c_CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q;
  logic [31:0] mem [c_WORDS];

  logic        w_accept;
  logic        w_commit;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_mask;
  logic [31:0] w_lanes;

  assign req_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_RESP));
  assign w_accept  = req_valid & req_ready;
  assign busy      = (state_q == S_WAIT) | (state_q == S_RESP);

  // With zero latency the commit happens on the accept edge itself, so the
  // access is taken straight from the request inputs; otherwise it comes from
  // the holding registers captured at accept.
  generate
    if (LATENCY == 0) begin : g_lat0
      assign w_we    = req_we;
      assign w_size  = req_size;
      assign w_uns   = req_unsigned;
      assign w_addr  = req_addr;
      assign w_wdata = req_wdata;
    end else begin : g_latn
      logic        we_q;
      logic [1:0]  size_q;
      logic        uns_q;
      logic [31:0] addr_q;
      logic [31:0] wdata_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          we_q    <= 1'b0;
          size_q  <= 2'b00;
          uns_q   <= 1'b0;
          addr_q  <= 32'h0;
          wdata_q <= 32'h0;
        end else if (w_accept) begin
          we_q    <= req_we;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
      end

      assign w_we    = we_q;
      assign w_size  = size_q;
      assign w_uns   = uns_q;
      assign w_addr  = addr_q;
      assign w_wdata = wdata_q;
    end
  endgenerate

  // Next-state logic; w_commit marks the edge that enters RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_commit = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            state_d  = S_RESP;
            w_commit = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = c_CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          w_commit = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_err = (w_size == 2'b11)
               | ((w_size == 2'b01) & w_addr[0])
               | ((w_size == 2'b10) & (w_addr[1:0] != 2'b00))
               | (|w_addr[31:DEPTH_LOG2+2]);
  assign w_idx  = w_addr[DEPTH_LOG2+1:2];
  assign w_word = mem[w_idx];

  // Load extraction (little-endian lanes) and store lane replication/mask.
  always_comb begin
    case (w_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    w_load  = 32'h0;
    w_mask  = 4'b0000;
    w_lanes = w_wdata;
    case (w_size)
      2'b00: begin
        w_load  = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_mask  = 4'b0001 << w_addr[1:0];
        w_lanes = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_load  = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        w_mask  = w_addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_load = w_word;
        w_mask = 4'b1111;
      end
      default: ;
    endcase

    resp_rdata_d = (w_we | w_err) ? 32'h0 : w_load;
  end

  // RAM is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (w_commit && !rst && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mask[i]) mem[w_idx][8*i +: 8] <= w_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= w_commit;
      resp_err_q   <= w_commit & w_err;
      if (w_commit) resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire
